// File: rtl/sr_fp_mul_pipe.sv
// Three-stage IEEE-754 multiplier with RNE / RTZ / stochastic rounding.
// S1 unpacks and classifies the operands, S2 multiplies, S3 rounds and packs into the output register.
// The class output is named res_class because "class" is a reserved word.
module sr_fp_mul_pipe #(
   parameter int unsigned exp_width      = 5,
   parameter int unsigned mant_width     = 10,
   parameter int unsigned num_round_bits = 8,
   parameter logic [31:0] lfsr_seed      = 32'hACE1_2024
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [exp_width+mant_width:0] a_src,
   input  logic [exp_width+mant_width:0] b_src,
   input  logic [1:0]                    mode,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [exp_width+mant_width:0] result,
   output logic [5:0]                    res_class,
   output logic [3:0]                    flags
);

   localparam int E          = int'(exp_width);
   localparam int M          = int'(mant_width);
   localparam int NR         = int'(num_round_bits);
   localparam int EW         = E + 2;
   localparam int XW         = E + 3;
   localparam int PW         = 2 * M + 2;
   localparam int SW         = 2 * M + 1;
   localparam int WX         = SW + NR + 2;
   localparam int MAX_SH     = M + NR + 2;
   localparam int BIAS       = (1 << (E - 1)) - 1;
   localparam int EMIN       = 1 - BIAS;
   localparam int EMAX_FIELD = (1 << E) - 1;

   localparam logic [1:0]  MODE_RTZ = 2'b01;
   localparam logic [1:0]  MODE_SR  = 2'b10;
   localparam logic [31:0] POLY     = 32'h8020_0003;
   localparam logic [E+M:0] QNAN    = {1'b0, {E{1'b1}}, 1'b1, {(M - 1){1'b0}}};

   // res_class bit positions: {zero, inf, subN, Norm, QNan, SNan}
   localparam int C_ZERO = 5, C_INF = 4, C_SUB = 3, C_NORM = 2, C_QNAN = 1, C_SNAN = 0;
   // flags bit positions: {invalid, overflow, underflow, inexact}
   localparam int F_INV = 3, F_OVF = 2, F_UNF = 1, F_INX = 0;

   typedef struct packed {
      logic                 sign;
      logic                 zero;
      logic                 inf;
      logic                 qnan;
      logic                 snan;
      logic signed [EW-1:0] exp;
      logic [M:0]           mant;
   } op_t;

   // Subnormals come out normalised (hidden bit set) with an exponent below EMIN.
   function automatic op_t unpack(input logic [E+M:0] x);
      op_t            o;
      logic [E-1:0]   ef;
      logic [M-1:0]   fr;
      int             lz;
      ef = x[E+M-1:M];
      fr = x[M-1:0];
      o = '0;
      o.sign = x[E+M];
      lz = M;
      for (int i = 0; i < M; i++) if (fr[i]) lz = M - 1 - i;
      if (ef == '1) begin
         o.inf  = (fr == '0);
         o.qnan = fr[M-1];
         o.snan = (fr != '0) && !fr[M-1];
      end else if (ef == '0) begin
         o.zero = (fr == '0);
         if (fr != '0) begin
            o.mant    = {1'b0, fr} << (lz + 1);
            o.mant[M] = 1'b1;
            o.exp     = EW'(EMIN - lz - 1);
         end
      end else begin
         o.mant = {1'b1, fr};
         o.exp  = EW'(int'(ef) - BIAS);
      end
      return o;
   endfunction

   logic s1_ready, s2_ready, s3_ready;
   logic s1_valid, s2_valid;

   logic [1:0]           s1_mode, s2_mode;
   logic                 s1_sign, s2_sign;
   logic                 s1_sp, s2_sp;
   logic [E+M:0]         s1_sp_res, s2_sp_res;
   logic [5:0]           s1_sp_cls, s2_sp_cls;
   logic [3:0]           s1_sp_flg, s2_sp_flg;
   logic signed [EW-1:0] s1_exp_a, s1_exp_b;
   logic [M:0]           s1_mant_a, s1_mant_b;
   logic signed [XW-1:0] s2_exp;
   logic [SW-1:0]        s2_sig;
   logic                 s2_sticky;
   logic [31:0]          lfsr_q;

   assign s3_ready = !out_valid || out_ready;
   assign s2_ready = !s2_valid || s3_ready;
   assign s1_ready = !s1_valid || s2_ready;
   assign in_ready = s1_ready;

   op_t          ua, ub;
   logic         sp_d, sign_d;
   logic [E+M:0] sp_res_d;
   logic [5:0]   sp_cls_d;
   logic [3:0]   sp_flg_d;

   // S1: classify operands and resolve special-case results by priority
   always_comb begin
      ua       = unpack(a_src);
      ub       = unpack(b_src);
      sign_d   = ua.sign ^ ub.sign;
      sp_d     = 1'b1;
      sp_res_d = '0;
      sp_cls_d = '0;
      sp_flg_d = '0;
      if (ua.snan || ub.snan) begin
         sp_res_d         = QNAN;
         sp_cls_d[C_SNAN] = 1'b1;
         sp_flg_d[F_INV]  = 1'b1;
      end else if (ua.qnan || ub.qnan) begin
         sp_res_d         = QNAN;
         sp_cls_d[C_QNAN] = 1'b1;
      end else if ((ua.inf && ub.zero) || (ua.zero && ub.inf)) begin
         sp_res_d         = QNAN;
         sp_cls_d[C_QNAN] = 1'b1;
         sp_flg_d[F_INV]  = 1'b1;
      end else if (ua.inf || ub.inf) begin
         sp_res_d        = {sign_d, {E{1'b1}}, {M{1'b0}}};
         sp_cls_d[C_INF] = 1'b1;
      end else if (ua.zero || ub.zero) begin
         sp_res_d         = {sign_d, {(E + M){1'b0}}};
         sp_cls_d[C_ZERO] = 1'b1;
      end else begin
         sp_d = 1'b0;
      end
   end

   logic [PW-1:0]        prod;
   logic signed [XW-1:0] exp_sum;

   // S2: multiply significands; a product >= 2.0 is normalised by one place
   always_comb begin
      prod    = PW'(s1_mant_a) * PW'(s1_mant_b);
      exp_sum = {s1_exp_a[EW-1], s1_exp_a} + {s1_exp_b[EW-1], s1_exp_b} + XW'(prod[PW-1]);
   end

   int               e2, sh, field;
   logic [WX-1:0]    ext, shifted;
   logic [2*WX-1:0]  wide;
   logic             hid, sb, tiny, inc, inexact, ovf;
   logic [M-1:0]     kf;
   logic [NR-1:0]    rb;
   logic [NR:0]      sr_sum;
   logic [M+1:0]     rm;
   logic [E+M:0]     res_d;
   logic [5:0]       cls_d;
   logic [3:0]       flg_d;
   logic             lfsr_adv;
   logic [31:0]      lfsr_d;

   // S3: denormalise tiny results, round per mode, detect overflow and pack
   always_comb begin
      e2   = int'(s2_exp);
      tiny = (e2 < EMIN);
      sh   = EMIN - e2;
      if (sh < 0) sh = 0;
      if (sh > MAX_SH) sh = MAX_SH;
      ext     = {s2_sig, {(NR + 2){1'b0}}};
      wide    = {ext, {WX{1'b0}}} >> sh;
      shifted = wide[2*WX-1:WX];
      hid     = shifted[WX-1];
      kf      = shifted[WX-2 -: M];
      rb      = shifted[WX-2-M -: NR];
      sb      = (|shifted[WX-M-NR-2:0]) || (|wide[WX-1:0]) || s2_sticky;
      sr_sum  = {1'b0, rb} + {1'b0, lfsr_q[NR-1:0]};
      case (s2_mode)
         MODE_RTZ: inc = 1'b0;
         MODE_SR:  inc = sr_sum[NR];
         default:  inc = rb[NR-1] && ((|rb[NR-2:0]) || sb || kf[0]);
      endcase
      rm      = {1'b0, hid, kf} + {{(M + 1){1'b0}}, inc};
      // A tiny result that carries into the hidden bit becomes the minimum normal.
      field   = tiny ? int'(rm[M]) : e2 + BIAS + int'(rm[M+1]);
      inexact = (rb != '0) || sb;
      ovf     = (field >= EMAX_FIELD);
      res_d   = '0;
      cls_d   = '0;
      flg_d   = '0;
      if (s2_sp) begin
         res_d = s2_sp_res;
         cls_d = s2_sp_cls;
         flg_d = s2_sp_flg;
      end else if (ovf) begin
         flg_d[F_OVF] = 1'b1;
         flg_d[F_INX] = 1'b1;
         if (s2_mode == MODE_RTZ) begin
            res_d         = {s2_sign, E'(EMAX_FIELD - 1), {M{1'b1}}};
            cls_d[C_NORM] = 1'b1;
         end else begin
            res_d        = {s2_sign, {E{1'b1}}, {M{1'b0}}};
            cls_d[C_INF] = 1'b1;
         end
      end else begin
         res_d        = {s2_sign, E'(field), rm[M-1:0]};
         flg_d[F_UNF] = tiny && inexact;
         flg_d[F_INX] = inexact;
         if (field == 0 && rm[M-1:0] == '0) cls_d[C_ZERO] = 1'b1;
         else if (field == 0)               cls_d[C_SUB]  = 1'b1;
         else                               cls_d[C_NORM] = 1'b1;
      end
      lfsr_adv = s2_valid && s3_ready && (s2_mode == MODE_SR);
      lfsr_d   = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? POLY : 32'h0);
   end

   // Control state: stage valids, output register and LFSR
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         out_valid <= 1'b0;
         result    <= '0;
         res_class <= '0;
         flags     <= '0;
         lfsr_q    <= lfsr_seed;
      end else begin
         if (s1_ready) s1_valid <= in_valid;
         if (s2_ready) s2_valid <= s1_valid;
         if (s3_ready) out_valid <= s2_valid;
         if (s2_valid && s3_ready) begin
            result    <= res_d;
            res_class <= cls_d;
            flags     <= flg_d;
         end
         if (lfsr_adv) lfsr_q <= lfsr_d;
      end
   end

   // Payload registers load only on a transfer into their stage
   always_ff @(posedge clk) begin
      if (in_valid && s1_ready) begin
         s1_mode   <= mode;
         s1_sign   <= sign_d;
         s1_sp     <= sp_d;
         s1_sp_res <= sp_res_d;
         s1_sp_cls <= sp_cls_d;
         s1_sp_flg <= sp_flg_d;
         s1_exp_a  <= ua.exp;
         s1_exp_b  <= ub.exp;
         s1_mant_a <= ua.mant;
         s1_mant_b <= ub.mant;
      end
      if (s1_valid && s2_ready) begin
         s2_mode   <= s1_mode;
         s2_sign   <= s1_sign;
         s2_sp     <= s1_sp;
         s2_sp_res <= s1_sp_res;
         s2_sp_cls <= s1_sp_cls;
         s2_sp_flg <= s1_sp_flg;
         s2_exp    <= exp_sum;
         s2_sig    <= prod[PW-1] ? prod[PW-1:1] : prod[SW-1:0];
         s2_sticky <= prod[PW-1] && prod[0];
      end
   end

endmodule

// File: tb/tb_sr_fp_mul_pipe.sv
// Directed bench for sr_fp_mul_pipe in its FP16 configuration.
module tb_sr_fp_mul_pipe;

   localparam logic [31:0] seed = 32'hACE1_2024;

   localparam logic [5:0] cl_zero = 6'b100000;
   localparam logic [5:0] cl_inf  = 6'b010000;
   localparam logic [5:0] cl_sub  = 6'b001000;
   localparam logic [5:0] cl_norm = 6'b000100;
   localparam logic [5:0] cl_qnan = 6'b000010;
   localparam logic [5:0] cl_snan = 6'b000001;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic [1:0]  m;
      logic [15:0] r;
      logic [5:0]  c;
      logic [3:0]  f;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, out_valid, out_ready;
   logic [15:0] a_src, b_src, result;
   logic [1:0]  mode;
   logic [5:0]  res_class;
   logic [3:0]  flags;

   always #5 clk = ~clk;

   sr_fp_mul_pipe #(
      .exp_width      (5),
      .mant_width     (10),
      .num_round_bits (8),
      .lfsr_seed      (seed)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_src     (a_src),
      .b_src     (b_src),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .res_class (res_class),
      .flags     (flags)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] lfsr_m;
   int          first_block;

   logic [15:0] op_a [1024];
   logic [15:0] op_b [1024];
   logic [1:0]  op_m [1024];
   logic [15:0] got_res [1024];
   logic [5:0]  got_cls [1024];
   logic [3:0]  got_flg [1024];
   int          got_cyc [1024];

   vec_t str_tab [8];
   vec_t dir_tab [12];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, want);
      end
   endtask

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
   endfunction

   // Expected SR result for 0x3E00*0x3C01 (R = 0x80) given the current LFSR value
   function automatic logic [15:0] sr_want(input logic [31:0] s);
      logic [8:0] sum;
      sum = 9'h080 + {1'b0, s[7:0]};
      return sum[8] ? 16'h3E02 : 16'h3E01;
   endfunction

   // Push op_*[0..n-1] through the DUT, holding out_ready low for the first 'stall' cycles.
   task automatic run_stream(input int n, input int stall);
      int sent, rcvd, cyc, limit;
      sent = 0;
      rcvd = 0;
      cyc = 0;
      limit = 2 * n + stall + 20;
      first_block = -1;
      while ((sent < n || rcvd < n) && cyc < limit) begin
         @(negedge clk);
         out_ready = (cyc >= stall);
         #1;
         if (out_valid && out_ready) begin
            got_res[rcvd] = result;
            got_cls[rcvd] = res_class;
            got_flg[rcvd] = flags;
            got_cyc[rcvd] = cyc;
            rcvd++;
         end
         if (sent < n) begin
            in_valid = 1'b1;
            a_src = op_a[sent];
            b_src = op_b[sent];
            mode = op_m[sent];
            if (in_ready) sent++;
            else if (first_block < 0) first_block = sent;
         end else begin
            in_valid = 1'b0;
         end
         cyc++;
      end
      check("stream_count", rcvd, n);
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int seq_err, ups, bad;
      int ov_seen;

      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      a_src = '0;
      b_src = '0;
      mode = 2'b00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_result", result, 0);
      check("rst_class", res_class, 0);
      check("rst_flags", flags, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_lfsr", dut.lfsr_q, seed);
      lfsr_m = seed;

      // Back-to-back RNE stream
      str_tab[0] = '{16'h3C00, 16'h4000, 2'b00, 16'h4000, cl_norm, 4'b0000};
      str_tab[1] = '{16'h4000, 16'h4000, 2'b00, 16'h4400, cl_norm, 4'b0000};
      str_tab[2] = '{16'h3800, 16'h3800, 2'b00, 16'h3400, cl_norm, 4'b0000};
      str_tab[3] = '{16'hC000, 16'h3C00, 2'b00, 16'hC000, cl_norm, 4'b0000};
      str_tab[4] = '{16'h4200, 16'h4200, 2'b00, 16'h4880, cl_norm, 4'b0000};
      str_tab[5] = '{16'hBC00, 16'hBC00, 2'b00, 16'h3C00, cl_norm, 4'b0000};
      str_tab[6] = '{16'h3E00, 16'h4000, 2'b00, 16'h4200, cl_norm, 4'b0000};
      str_tab[7] = '{16'h8000, 16'h3C00, 2'b00, 16'h8000, cl_zero, 4'b0000};
      for (int i = 0; i < 8; i++) begin
         op_a[i] = str_tab[i].a;
         op_b[i] = str_tab[i].b;
         op_m[i] = str_tab[i].m;
      end
      run_stream(8, 0);
      check("str_latency", got_cyc[0], 3);
      check("str_back_to_back", got_cyc[7] - got_cyc[0], 7);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("str%0d_res", i), got_res[i], str_tab[i].r);
         check($sformatf("str%0d_cls", i), got_cls[i], str_tab[i].c);
         check($sformatf("str%0d_flg", i), got_flg[i], str_tab[i].f);
      end

      // Rounding, overflow, special and subnormal cases
      dir_tab[0]  = '{16'h3E00, 16'h3C01, 2'b00, 16'h3E02, cl_norm, 4'b0001};
      dir_tab[1]  = '{16'h3E00, 16'h3C01, 2'b01, 16'h3E01, cl_norm, 4'b0001};
      dir_tab[2]  = '{16'h7BFF, 16'h4000, 2'b00, 16'h7C00, cl_inf,  4'b0101};
      dir_tab[3]  = '{16'h7BFF, 16'h4000, 2'b01, 16'h7BFF, cl_norm, 4'b0101};
      dir_tab[4]  = '{16'h7C00, 16'h0000, 2'b00, 16'h7E00, cl_qnan, 4'b1000};
      dir_tab[5]  = '{16'h7D00, 16'h3C00, 2'b00, 16'h7E00, cl_snan, 4'b1000};
      dir_tab[6]  = '{16'h0001, 16'h3800, 2'b00, 16'h0000, cl_zero, 4'b0011};
      dir_tab[7]  = '{16'h0200, 16'h4000, 2'b00, 16'h0400, cl_norm, 4'b0000};
      dir_tab[8]  = '{16'h0003, 16'h3C00, 2'b00, 16'h0003, cl_sub,  4'b0000};
      dir_tab[9]  = '{16'h3E00, 16'h3C01, 2'b11, 16'h3E02, cl_norm, 4'b0001};
      dir_tab[10] = '{16'h7C00, 16'hC000, 2'b00, 16'hFC00, cl_inf,  4'b0000};
      dir_tab[11] = '{16'h7E00, 16'h3C00, 2'b01, 16'h7E00, cl_qnan, 4'b0000};
      for (int i = 0; i < 12; i++) begin
         op_a[i] = dir_tab[i].a;
         op_b[i] = dir_tab[i].b;
         op_m[i] = dir_tab[i].m;
      end
      run_stream(12, 0);
      for (int i = 0; i < 12; i++) begin
         check($sformatf("dir%0d_res", i), got_res[i], dir_tab[i].r);
         check($sformatf("dir%0d_cls", i), got_cls[i], dir_tab[i].c);
         check($sformatf("dir%0d_flg", i), got_flg[i], dir_tab[i].f);
      end

      // Stochastic rounding over 1024 operations
      for (int i = 0; i < 1024; i++) begin
         op_a[i] = 16'h3E00;
         op_b[i] = 16'h3C01;
         op_m[i] = 2'b10;
      end
      run_stream(1024, 0);
      seq_err = 0;
      ups = 0;
      bad = 0;
      for (int i = 0; i < 1024; i++) begin
         if (got_res[i] !== sr_want(lfsr_m)) seq_err++;
         if (got_res[i] === 16'h3E02) ups++;
         else if (got_res[i] !== 16'h3E01) bad++;
         lfsr_m = lfsr_step(lfsr_m);
      end
      check("sr_seq_errors", seq_err, 0);
      check("sr_bad_values", bad, 0);
      check("sr_up_count_in_range", (ups >= 448 && ups <= 576), 1);
      check("sr_lfsr_state", dut.lfsr_q, lfsr_m);

      // Backpressure: out_ready low for 5 cycles while 6 SR ops stream in
      for (int i = 0; i < 6; i++) begin
         op_a[i] = 16'h3E00;
         op_b[i] = 16'h3C01;
         op_m[i] = 2'b10;
      end
      run_stream(6, 5);
      check("bp_ops_before_block", first_block, 3);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("bp%0d_res", i), got_res[i], sr_want(lfsr_m));
         lfsr_m = lfsr_step(lfsr_m);
      end
      check("bp_order_gap", got_cyc[5] - got_cyc[0], 5);
      check("bp_lfsr_state", dut.lfsr_q, lfsr_m);

      // Reset with two operations in flight
      @(negedge clk);
      in_valid = 1'b1;
      a_src = 16'h3C00;
      b_src = 16'h4000;
      mode = 2'b10;
      @(negedge clk);
      a_src = 16'h4000;
      b_src = 16'h4000;
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_lfsr", dut.lfsr_q, seed);
      rst = 1'b0;
      lfsr_m = seed;
      #1;
      check("midrst_in_ready", in_ready, 1);
      ov_seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) ov_seen++;
      end
      check("midrst_no_stale", ov_seen, 0);

      // LFSR restarts from the seed after reset
      op_a[0] = 16'h3E00;
      op_b[0] = 16'h3C01;
      op_m[0] = 2'b10;
      run_stream(1, 0);
      check("post_rst_sr_res", got_res[0], sr_want(lfsr_m));
      lfsr_m = lfsr_step(lfsr_m);
      check("post_rst_lfsr", dut.lfsr_q, lfsr_m);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/sr_fp_mul_pipe.md
Name: sr_fp_mul_pipe

Overview:
Pipelined IEEE-754 binary multiplier with selectable rounding: round-to-nearest-even (RNE), round-toward-zero (RTZ) or stochastic rounding (SR). Parametrised over exponent and mantissa widths, so FP16 and FP32 use the same block. It classifies operands internally, normalises subnormal inputs, multiplies, then denormalises, rounds and packs. It sits in the SRFPU datapath behind operand issue, with a valid/ready handshake on both sides.

Parameters:
exp_width, 5, exponent field width; bias = 2^(exp_width-1)-1
mant_width, 10, stored fraction width
num_round_bits, 8, truncated bits compared against random value in SR mode
lfsr_seed, 32'hACE1_2024, LFSR reset value; must be nonzero

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  block accepts operands this cycle
a_src  in  1+exp_width+mant_width  operand A
b_src  in  1+exp_width+mant_width  operand B
mode  in  2  00 RNE, 01 RTZ, 10 SR, 11 treated as RNE; sampled with operands
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
result  out  1+exp_width+mant_width  packed product
class  out  6  {zero,inf,subN,Norm,QNan,SNan} of result; SNan = a signalling-NaN operand was seen
flags  out  4  {invalid,overflow,underflow,inexact}

Behaviour:
- Reset: all stage valids, out_valid, result, class and flags = 0; LFSR = lfsr_seed. in_ready = 1 in the cycle after reset deasserts. A reset in the middle of operation discards all in-flight operations and produces no partial outputs.
- Three stages; output is registered. A transfer occurs when valid&ready. Per stage, ready_i = !valid_i | ready_(i+1); stage 3 ready = !out_valid | out_ready; in_ready = stage-1 ready. Latency is 3 cycles from input transfer to out_valid. With no backpressure, throughput is 1 operation per clock. Order is preserved. No drop or duplication under any stall pattern. Bubbles collapse.
- S1 (unpack):
  - Classify each operand from its encoding as zero, subnormal, normal, inf, qNaN or sNaN.
  - For a subnormal operand: shift = clz of the fraction. mant = fraction << (shift+1) with the hidden bit forced to 1. exp = 1 - bias - (shift+1).
  - For a normal operand: exp = field - bias; mant = {1, fraction}.
  - Exponents are signed, exp_width+2 bits wide.
- S2: prod = mant_a*mant_b, 2*mant_width+2 bits. exp = exp_a + exp_b. If prod MSB is set, exp is incremented and prod is treated as right-shifted by 1, with the shifted-out bit ORed into sticky.
- S3 (round and pack):
  - Denormalise: if exp < 1-bias, right shift by (1-bias-exp), saturating at mant_width+num_round_bits+2. Shifted-out bits go to sticky.
  - Kept fraction K is the top mant_width bits below the hidden bit. R is the next num_round_bits bits. S is the OR of all remaining bits.
  - RNE: increment iff (R[msb] & (R[msb-1:0]!=0 | S | K[0])).
  - RTZ: never increment.
  - SR: increment iff R + lfsr[num_round_bits-1:0] >= 2^num_round_bits. S does not affect the SR decision.
  - A carry out of K renormalises: exp+1. A subnormal that carries becomes the minimum normal with Norm class.
  - The LFSR is a 32-bit Galois LFSR with polynomial x^32+x^22+x^2+x+1. It advances exactly once per stage-3 transfer of a SR-mode operation. It holds during stalls, so the random sequence per transaction is deterministic.
- Overflow (rounded exp > bias):
  - RNE and SR give ±inf with overflow=1 and inexact=1.
  - RTZ gives ±max finite with overflow=1 and inexact=1.
- Underflow = 1 when the result is tiny (exp before rounding < 1-bias) and inexact. A result that rounds to 0 gives ±0 with class zero.
- inexact = (R!=0 | S).
- Special cases, highest priority first:
  - Any sNaN operand: canonical qNaN {0, all 1, 1, 0...}, SNan=1, invalid=1.
  - Any qNaN operand: canonical qNaN, QNan=1.
  - inf*0: canonical qNaN, QNan=1, invalid=1.
  - inf*finite: ±inf.
  - zero*finite: ±0.
  - The sign is always a_sign^b_sign except for NaN results.
- mode is captured in S1 and carried through the pipeline with its operation.

Test Plan:
- FP16, RNE, no stall: 0x3C00*0x4000 -> 0x4000 exactly 3 cycles later, class Norm, flags 0; streaming 8 pairs gives 8 back-to-back results.
- 0x3E00*0x3C01 (1.5*(1+2^-10), R=0x80): RNE -> 0x3E02, inexact; RTZ -> 0x3E01; SR over 1024 ops -> only 0x3E01 or 0x3E02, 0x3E02 count within 512±64, and the sequence matches the reference LFSR model.
- 0x7BFF*0x4000: RNE -> 0x7C00 with overflow+inexact; RTZ -> 0x7BFF with overflow+inexact. 0x7C00*0x0000 -> 0x7E00 with invalid, QNan. 0x7D00*0x3C00 -> 0x7E00 with SNan, invalid.
- Subnormal: 0x0001*0x3800 -> RNE 0x0000 with underflow+inexact, class zero; 0x0200*0x4000 -> 0x0400 with class Norm; 0x0003*0x3C00 -> 0x0003 with class subN, flags 0.
- Backpressure: stream 6 ops with out_ready low for 5 cycles -> in_ready drops after 3 ops are held; after release all 6 results appear in order; the LFSR advances only on transfers.
- Reset asserted with 2 ops in flight -> out_valid=0 next cycle, no stale result later, LFSR = lfsr_seed.
